// File: rtl/sound_pkg.sv
// Shared register map, status bit positions and NMI state type for the
// 68k <-> 6502 sound mailbox.
package sound_pkg;

  localparam logic [1:0] MBX_DATA  = 2'd0;
  localparam logic [1:0] MBX_STAT  = 2'd1;
  localparam logic [1:0] MBX_CLR   = 2'd2;
  localparam logic [1:0] MBX_FLUSH = 2'd3;

  // Status bit positions; MBX_CLR write data uses the same positions for the flags.
  localparam int ST_M2S_NE   = 0;
  localparam int ST_S2M_FULL = 1;
  localparam int ST_OVF_M2S  = 2;
  localparam int ST_OVF_S2M  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } nmi_state_t;

endpackage

// File: rtl/mailbox_fifo.sv
// Small synchronous FIFO with a registered head word (0 when empty), flush,
// and an overflow pulse for pushes rejected because the FIFO is full.
module mailbox_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      w_wr_ptr_next;
  logic [AW:0]      w_rd_ptr_next;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] w_head_next;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop   = i_pop && !o_empty && !i_flush;
  assign w_do_push  = i_push && (!o_full || w_do_pop) && !i_flush;
  assign o_overflow = i_push && o_full && !w_do_pop && !i_flush;
  assign o_head     = r_head;

  always_comb begin
    w_wr_ptr_next = r_wr_ptr;
    w_rd_ptr_next = r_rd_ptr;
    w_head_next   = '0;
    if (i_flush) begin
      w_wr_ptr_next = '0;
      w_rd_ptr_next = '0;
    end else begin
      if (w_do_push) w_wr_ptr_next = r_wr_ptr + PTR_ONE;
      if (w_do_pop)  w_rd_ptr_next = r_rd_ptr + PTR_ONE;
    end
    // The new head may be the word being written this very cycle.
    if (w_wr_ptr_next != w_rd_ptr_next) begin
      if (w_do_push && (w_rd_ptr_next[AW-1:0] == r_wr_ptr[AW-1:0]))
        w_head_next = i_din;
      else
        w_head_next = r_mem[w_rd_ptr_next[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_head   <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
      r_head   <= w_head_next;
    end
  end

endmodule

// File: rtl/sound_mailbox.sv
// Bidirectional 68k <-> 6502 mailbox: command FIFO towards the sound CPU, response
// FIFO back to the main CPU, edge-qualified strobes, sticky overflow flags and NMI.
module sound_mailbox
  import sound_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int M2S_DEPTH = 4,
  parameter int S2M_DEPTH = 4,
  parameter int NMI_LEN   = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              main_wr_b,
  input  logic              main_rd_b,
  input  logic [DATA_W-1:0] main_din,
  output logic [DATA_W-1:0] main_dout,
  output logic              main_irq_b,
  output logic              main_full,
  input  logic              snd_cs_b,
  input  logic              snd_wr_b,
  input  logic              snd_rd_b,
  input  logic [1:0]        snd_a,
  input  logic [DATA_W-1:0] snd_din,
  output logic [DATA_W-1:0] snd_dout,
  output logic              snd_nmi_b
);

  localparam int CW = $clog2(NMI_LEN + 1);
  localparam logic [CW-1:0] NMI_LOAD = CW'(NMI_LEN);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic r_main_wr_prev, r_main_rd_prev, r_snd_wr_prev, r_snd_rd_prev;
  logic w_main_wr_fire, w_main_rd_fire, w_snd_wr_fire, w_snd_rd_fire;
  logic w_flush, w_m2s_pop, w_s2m_push, w_m2s_accept;

  logic [DATA_W-1:0] w_m2s_head, w_s2m_head, w_status;
  logic w_m2s_full, w_m2s_empty, w_m2s_ovf;
  logic w_s2m_full, w_s2m_empty, w_s2m_ovf;
  logic r_ovf_m2s, r_ovf_s2m;
  logic [DATA_W-1:0] r_snd_dout;

  nmi_state_t r_state, w_state_next;
  logic [CW-1:0] r_nmi_cnt, w_nmi_cnt_next;
  logic w_nmi_b;

  // An access fires only on the first low cycle after the strobe was high.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_main_wr_prev <= 1'b1;
      r_main_rd_prev <= 1'b1;
      r_snd_wr_prev  <= 1'b1;
      r_snd_rd_prev  <= 1'b1;
    end else begin
      r_main_wr_prev <= main_wr_b;
      r_main_rd_prev <= main_rd_b;
      r_snd_wr_prev  <= snd_wr_b;
      r_snd_rd_prev  <= snd_rd_b;
    end
  end

  assign w_main_wr_fire = !main_wr_b && r_main_wr_prev;
  assign w_main_rd_fire = !main_rd_b && r_main_rd_prev;
  assign w_snd_wr_fire  = !snd_wr_b && r_snd_wr_prev && !snd_cs_b;
  assign w_snd_rd_fire  = !snd_rd_b && r_snd_rd_prev && !snd_cs_b;

  assign w_flush    = w_snd_wr_fire && (snd_a == MBX_FLUSH);
  assign w_m2s_pop  = w_snd_rd_fire && (snd_a == MBX_DATA);
  assign w_s2m_push = w_snd_wr_fire && (snd_a == MBX_DATA);
  // Any main write that neither overflowed nor lost to a flush was stored.
  assign w_m2s_accept = w_main_wr_fire && !w_m2s_ovf && !w_flush;

  mailbox_fifo #(.WIDTH(DATA_W), .DEPTH(M2S_DEPTH)) u_m2s (
    .clk        (clk),
    .rst_b      (rst_b),
    .i_push     (w_main_wr_fire),
    .i_pop      (w_m2s_pop),
    .i_flush    (w_flush),
    .i_din      (main_din),
    .o_head     (w_m2s_head),
    .o_full     (w_m2s_full),
    .o_empty    (w_m2s_empty),
    .o_overflow (w_m2s_ovf)
  );

  mailbox_fifo #(.WIDTH(DATA_W), .DEPTH(S2M_DEPTH)) u_s2m (
    .clk        (clk),
    .rst_b      (rst_b),
    .i_push     (w_s2m_push),
    .i_pop      (w_main_rd_fire),
    .i_flush    (w_flush),
    .i_din      (snd_din),
    .o_head     (w_s2m_head),
    .o_full     (w_s2m_full),
    .o_empty    (w_s2m_empty),
    .o_overflow (w_s2m_ovf)
  );

  assign main_dout  = w_s2m_head;
  assign main_irq_b = w_s2m_empty;
  assign main_full  = w_m2s_full;

  // A new overflow in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_ovf_m2s <= 1'b0;
      r_ovf_s2m <= 1'b0;
    end else begin
      if (w_snd_wr_fire && (snd_a == MBX_CLR)) begin
        if (snd_din[ST_OVF_M2S]) r_ovf_m2s <= 1'b0;
        if (snd_din[ST_OVF_S2M]) r_ovf_s2m <= 1'b0;
      end
      if (w_m2s_ovf) r_ovf_m2s <= 1'b1;
      if (w_s2m_ovf) r_ovf_s2m <= 1'b1;
    end
  end

  always_comb begin
    w_status              = '0;
    w_status[ST_M2S_NE]   = !w_m2s_empty;
    w_status[ST_S2M_FULL] = w_s2m_full;
    w_status[ST_OVF_M2S]  = r_ovf_m2s;
    w_status[ST_OVF_S2M]  = r_ovf_s2m;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_snd_dout <= '0;
    end else if (w_snd_rd_fire) begin
      case (snd_a)
        MBX_DATA: r_snd_dout <= w_m2s_head;
        MBX_STAT: r_snd_dout <= w_status;
        default:  r_snd_dout <= '0;
      endcase
    end
  end

  assign snd_dout = r_snd_dout;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state   <= IDLE;
      r_nmi_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_nmi_cnt <= w_nmi_cnt_next;
    end
  end

  // Pushes arriving during a pulse are covered by it; the 6502 drains via status.
  always_comb begin
    w_state_next   = r_state;
    w_nmi_cnt_next = r_nmi_cnt;
    w_nmi_b        = 1'b1;
    case (r_state)
      IDLE: begin
        if (w_m2s_accept) begin
          w_state_next   = PULSE;
          w_nmi_cnt_next = NMI_LOAD;
        end
      end
      PULSE: begin
        w_nmi_b = 1'b0;
        if (r_nmi_cnt <= CNT_ONE) begin
          w_state_next   = IDLE;
          w_nmi_cnt_next = '0;
        end else begin
          w_nmi_cnt_next = r_nmi_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_next   = IDLE;
        w_nmi_cnt_next = '0;
      end
    endcase
  end

  assign snd_nmi_b = w_nmi_b;

endmodule

// File: tb/tb_sound_mailbox.sv
// Scoreboard bench for sound_mailbox: directed scenarios plus random bus traffic
// checked against a queue-based model of both mailboxes and the NMI rule.
module tb_sound_mailbox;
  import sound_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int NLEN  = 4;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          main_wr_b = 1'b1, main_rd_b = 1'b1;
  logic [DW-1:0] main_din = '0, main_dout;
  logic          main_irq_b, main_full;
  logic          snd_cs_b = 1'b1, snd_wr_b = 1'b1, snd_rd_b = 1'b1;
  logic [1:0]    snd_a = 2'd0;
  logic [DW-1:0] snd_din = '0, snd_dout;
  logic          snd_nmi_b;

  always #5 clk = ~clk;

  sound_mailbox #(.DATA_W(DW), .M2S_DEPTH(DEPTH), .S2M_DEPTH(DEPTH), .NMI_LEN(NLEN)) dut (
    .clk(clk), .rst_b(rst_b),
    .main_wr_b(main_wr_b), .main_rd_b(main_rd_b), .main_din(main_din),
    .main_dout(main_dout), .main_irq_b(main_irq_b), .main_full(main_full),
    .snd_cs_b(snd_cs_b), .snd_wr_b(snd_wr_b), .snd_rd_b(snd_rd_b), .snd_a(snd_a),
    .snd_din(snd_din), .snd_dout(snd_dout), .snd_nmi_b(snd_nmi_b)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model
  logic [7:0] m2s_q[$];
  logic [7:0] s2m_q[$];
  logic       ovf_m2s_m = 1'b0, ovf_s2m_m = 1'b0;
  logic [7:0] exp_snd_q[$];
  logic [7:0] exp_main_q[$];
  int         exp_pulses = 0;
  int         nmi_idle_cyc = 0;
  int         nmi_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] model_status();
    return {4'b0000, ovf_s2m_m, ovf_m2s_m, (s2m_q.size() == DEPTH), (m2s_q.size() != 0)};
  endfunction

  // One bus transaction; strobes held for 'hold' cycles, all firing on the same edge.
  task automatic op(input logic mw, input logic mr, input logic sw, input logic sr,
                    input logic [1:0] a, input logic [7:0] md, input logic [7:0] sd,
                    input int hold);
    int fc;
    logic [7:0] e;
    @(negedge clk);
    fc = cyc + 1;
    if (sr) begin
      case (a)
        MBX_DATA: e = (m2s_q.size() != 0) ? m2s_q[0] : 8'h00;
        MBX_STAT: e = model_status();
        default:  e = 8'h00;
      endcase
      exp_snd_q.push_back(e);
    end
    if (mr) exp_main_q.push_back((s2m_q.size() != 0) ? s2m_q[0] : 8'h00);
    if (sw && a == MBX_CLR) begin
      if (sd[3]) ovf_s2m_m = 1'b0;
      if (sd[2]) ovf_m2s_m = 1'b0;
    end
    if (sw && a == MBX_FLUSH) begin
      m2s_q.delete();
      s2m_q.delete();
    end else begin
      if (sr && a == MBX_DATA && m2s_q.size() != 0) void'(m2s_q.pop_front());
      if (mw) begin
        if (m2s_q.size() < DEPTH) begin
          m2s_q.push_back(md);
          if (fc >= nmi_idle_cyc) begin
            exp_pulses++;
            nmi_idle_cyc = fc + NLEN + 1;
          end
        end else ovf_m2s_m = 1'b1;
      end
      if (mr && s2m_q.size() != 0) void'(s2m_q.pop_front());
      if (sw && a == MBX_DATA) begin
        if (s2m_q.size() < DEPTH) s2m_q.push_back(sd);
        else ovf_s2m_m = 1'b1;
      end
    end
    main_wr_b = !mw; main_rd_b = !mr; main_din = md;
    snd_cs_b = !(sw || sr); snd_wr_b = !sw; snd_rd_b = !sr; snd_a = a; snd_din = sd;
    repeat (hold) @(negedge clk);
    main_wr_b = 1'b1; main_rd_b = 1'b1; snd_cs_b = 1'b1; snd_wr_b = 1'b1; snd_rd_b = 1'b1;
    check("main_full", main_full, (m2s_q.size() == DEPTH));
    check("main_irq_b", main_irq_b, (s2m_q.size() == 0));
    check("main_dout", main_dout, (s2m_q.size() != 0) ? s2m_q[0] : 8'h00);
  endtask

  task automatic mwrite(input logic [7:0] d);  op(1, 0, 0, 0, 2'd0, d, 8'h00, 1); endtask
  task automatic mread();                      op(0, 1, 0, 0, 2'd0, 8'h00, 8'h00, 1); endtask
  task automatic swrite(input logic [1:0] a, input logic [7:0] d); op(0, 0, 1, 0, a, 8'h00, d, 1); endtask
  task automatic sread(input logic [1:0] a);   op(0, 0, 0, 1, a, 8'h00, 8'h00, 1); endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_nmi_b"}, snd_nmi_b, 1'b1);
    check({tag, "_main_dout"}, main_dout, 8'h00);
    check({tag, "_snd_dout"}, snd_dout, 8'h00);
    check({tag, "_irq_b"}, main_irq_b, 1'b1);
    check({tag, "_full"}, main_full, 1'b0);
  endtask

  // Scoreboard monitor: compares read data whenever the DUT returns it.
  initial begin : scoreboard
    logic prev_sr, prev_mr, fs, fm;
    logic [7:0] pre_md;
    prev_sr = 1'b1; prev_mr = 1'b1; pre_md = 8'h00;
    forever begin
      @(posedge clk);
      fs = rst_b && !snd_rd_b && !snd_cs_b && prev_sr;
      fm = rst_b && !main_rd_b && prev_mr;
      prev_sr = rst_b ? snd_rd_b : 1'b1;
      prev_mr = rst_b ? main_rd_b : 1'b1;
      @(negedge clk); #1;
      if (fs) begin
        if (exp_snd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL snd_read: got %0h, required no read", snd_dout);
        end else check("snd_dout", snd_dout, exp_snd_q.pop_front());
      end
      if (fm) begin
        if (exp_main_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL main_read: got %0h, required no read", pre_md);
        end else check("main_read", pre_md, exp_main_q.pop_front());
      end
      pre_md = main_dout;
    end
  end

  // NMI monitor: counts pulses and checks every completed pulse length.
  initial begin : nmi_mon
    int low;
    logic prev;
    low = 0; prev = 1'b1;
    forever begin
      @(negedge clk); #1;
      if (!rst_b) begin
        low = 0; prev = 1'b1;
      end else if (!snd_nmi_b) begin
        if (prev) nmi_pulses++;
        low++;
        prev = 1'b0;
      end else begin
        if (!prev) check("nmi_len", low, NLEN);
        low = 0; prev = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int p0;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    rst_b = 1'b1;
    repeat (2) @(negedge clk);

    // 1: reset during the second NMI pulse cycle aborts it at once
    mwrite(8'h21);
    @(posedge clk); #2;
    rst_b = 1'b0;
    #1;
    check_reset_values("rst_mid");
    m2s_q.delete(); s2m_q.delete();
    ovf_m2s_m = 1'b0; ovf_s2m_m = 1'b0; nmi_idle_cyc = 0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    sread(MBX_STAT);

    // 2: two commands, one NMI, in-order readout
    p0 = nmi_pulses;
    mwrite(8'h11); mwrite(8'h22);
    repeat (8) @(negedge clk);
    check("nmi_count_t2", nmi_pulses - p0, 1);
    sread(MBX_STAT); sread(MBX_DATA); sread(MBX_DATA); sread(MBX_STAT);

    // 3: overflow of the command FIFO, then clear
    for (int i = 1; i <= 5; i++) mwrite(8'(i));
    sread(MBX_STAT);
    for (int i = 0; i < 4; i++) sread(MBX_DATA);
    swrite(MBX_CLR, 8'h04);
    sread(MBX_STAT);

    // 4: response path and IRQ
    swrite(MBX_DATA, 8'hA5);
    mread();

    // 5: strobe held low for 10 cycles
    repeat (8) @(negedge clk);
    p0 = nmi_pulses;
    op(1, 0, 0, 0, 2'd0, 8'h33, 8'h00, 10);
    repeat (8) @(negedge clk);
    check("nmi_count_t5", nmi_pulses - p0, 1);
    sread(MBX_DATA); sread(MBX_DATA);

    // 6: push and pop on a full FIFO in the same cycle, then flush
    for (int i = 0; i < 4; i++) mwrite(8'h61 + 8'(i));
    op(1, 0, 0, 1, MBX_DATA, 8'h65, 8'h00, 1);
    sread(MBX_STAT);
    swrite(MBX_FLUSH, 8'h00);
    sread(MBX_STAT);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      int kind, hold;
      kind = $urandom_range(0, 9);
      hold = $urandom_range(1, 3);
      case (kind)
        0, 1, 2: op(1, 0, 0, 0, MBX_DATA, 8'($urandom), 8'h00, hold);
        3:       op(0, 1, 0, 0, MBX_DATA, 8'h00, 8'h00, hold);
        4, 5:    op(0, 0, 0, 1, MBX_DATA, 8'h00, 8'h00, hold);
        6:       op(0, 0, 1, 0, MBX_DATA, 8'h00, 8'($urandom), hold);
        7:       op(0, 0, 0, 1, MBX_STAT, 8'h00, 8'h00, hold);
        8:       op(0, 0, 1, 0, MBX_CLR, 8'h00, 8'($urandom), hold);
        default: begin
          if ($urandom_range(0, 3) == 0) op(0, 0, 1, 0, MBX_FLUSH, 8'h00, 8'h00, hold);
          else if ($urandom_range(0, 1) == 0) op(0, 0, 0, 1, 2'($urandom_range(2, 3)), 8'h00, 8'h00, hold);
          else op(0, 0, 1, 0, MBX_STAT, 8'h00, 8'($urandom), hold);
        end
      endcase
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end

    repeat (12) @(negedge clk);
    check("nmi_total", nmi_pulses, exp_pulses);
    check("snd_pending", exp_snd_q.size(), 0);
    check("main_pending", exp_main_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sound_mailbox.md
Name: sound_mailbox

Overview:
Parametrised bidirectional command mailbox between the main 68k and the I/O-sound 6502. It replaces the single 68k↔sound latch pair with two FIFOs:
- main→sound (M2S) carries commands;
- sound→main (S2M) carries responses.

It generates the 6502 NMI on command arrival and the 68k IRQ on response availability. It sits on the sound-side 68k chip-select (RD68k_b/WR68k_b decode) and on the main-side sound-port decode.

Parameters:
DATA_W, 8, data width of both FIFOs and both buses
M2S_DEPTH, 4, M2S FIFO entries (power of 2, ≥2)
S2M_DEPTH, 4, S2M FIFO entries (power of 2, ≥2)
NMI_LEN, 4, clk cycles snd_nmi_b is held low per NMI (≥1)

Ports:
clk  in  1  system clock
rst_b  in  1  asynchronous active-low reset
main_wr_b  in  1  main write strobe, level, active-low
main_rd_b  in  1  main read strobe, level, active-low
main_din  in  DATA_W  command from 68k
main_dout  out  DATA_W  S2M head (registered)
main_irq_b  out  1  low while S2M non-empty
main_full  out  1  M2S full
snd_cs_b  in  1  sound-side chip select, active-low
snd_wr_b  in  1  sound write strobe (WR68k_b), active-low
snd_rd_b  in  1  sound read strobe (RD68k_b), active-low
snd_a  in  2  register select
snd_din  in  DATA_W  6502 write data
snd_dout  out  DATA_W  6502 read data (registered)
snd_nmi_b  out  1  NMI to 6502, active-low pulse

Behaviour:
Reset:
- Async on rst_b low: both FIFOs empty, overflow flags clear.
- main_dout=0, snd_dout=0, main_irq_b=1, main_full=0, snd_nmi_b=1, NMI counter=0.
- Reset mid-pulse aborts the NMI immediately.

Access detection:
- Every strobe is edge-qualified. An access fires once, on the first clk where the strobe is low and was high on the previous clk.
- Holding a strobe low never repeats the action.
- Sound-side strobes count only with snd_cs_b=0 sampled in the same cycle.

Main side:
- main write: push main_din to M2S if not full. If full, drop the data and set sticky ovf_m2s.
- main read: pop S2M if non-empty. main_dout updates to the new head on the next cycle.
- main_dout always shows the S2M head; it shows 0 when S2M is empty.
- Read of empty S2M: no change.

Sound side, snd_a map:
- 0, read: return M2S head into snd_dout and pop. Empty → return 0, no pop.
- 0, write: push snd_din to S2M. Full → drop and set ovf_s2m.
- 1, read: status = {.., ovf_s2m[3], ovf_m2s[2], s2m_full[1], m2s_nonempty[0]}, upper bits 0.
- 1, write: ignored.
- 2, write: clear the overflow flags whose bits are 1 in snd_din[3:2].
- 3, write: flush both FIFOs.
- 2/3, read: return 0.
- snd_dout is registered: valid the cycle after the access and held until the next sound read.

Simultaneous events:
- Push and pop on the same FIFO in one cycle both occur; count is unchanged and data order is preserved.
- When full, simultaneous push+pop succeeds with no overflow.
- Pop of empty with simultaneous push: the pop is ignored, the push succeeds.
- Flush wins over a same-cycle push or pop.

NMI state machine (IDLE, PULSE):
- IDLE→PULSE on any accepted M2S push. Load the counter with NMI_LEN and drive snd_nmi_b=0.
- In PULSE, decrement the counter each cycle. At counter=1, go to IDLE next cycle with snd_nmi_b=1.
- A push during PULSE does not extend or retrigger the pulse; one NMI may cover several commands, and the 6502 drains via status.

Pointers: log2(depth)+1 bits each. Full when MSBs differ and LSBs are equal; wrap is natural modulo.

main_irq_b and main_full are combinational from FIFO state registers (glitch-free, no input paths).

Decomposition:
- Package sound_pkg:
  - register address constants MBX_DATA=0, MBX_STAT=1, MBX_CLR=2, MBX_FLUSH=3;
  - status bit indices;
  - typedef nmi_state_t {IDLE, PULSE}.
- One sub-module, mailbox_fifo (params WIDTH, DEPTH):
  - inputs push, pop, flush;
  - outputs head, full, empty, overflow pulse;
  - instantiated twice.

Test Plan:
1. Reset mid-NMI: push 8'h21, then pull rst_b low in PULSE cycle 2 → snd_nmi_b=1 at once; all outputs reach reset values; status reads 0.
2. Main writes 8'h11,8'h22 → one NMI pulse exactly 4 cycles low. Status reads 1. Two data reads → 8'h11 then 8'h22. Status then reads 0.
3. Main writes 5 bytes 8'h01..8'h05 with depth 4 → main_full=1 after the 4th write. Status reads 8'h05. Data reads return 01..04. Write MBX_CLR 8'h04 → status 0.
4. 6502 writes 8'hA5 → main_irq_b=0 and main_dout=A5 next cycle. Main read → main_irq_b=1, main_dout=0.
5. Strobe held low 10 cycles on a main write of 8'h33 → exactly one entry pushed, one NMI pulse.
6. M2S full; main push and sound data-read in the same cycle → pop returns the oldest entry, count stays 4, ovf_m2s stays 0. Then MBX_FLUSH → status 0.
